// File: rtl/bls_controller.sv
// Scheduler between the packet-register bank and BSMODS Black-Scholes modules.
// Define BLS_ROUND_ROBIN_EN for round-robin serve arbitration (default: fixed priority).
module bls_controller #(
    parameter int unsigned BSMODS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              DONE_WRITING,
    input  logic              OutOfData,
    input  logic [BSMODS-1:0] BS_READY,
    input  logic [BSMODS-1:0] BS_DONE,
    input  logic [BSMODS-1:0] BS_IDLE,
    input  logic [BSMODS-1:0] hasUnusedData,
    input  logic [BSMODS-1:0] REG_READY,
    output logic [BSMODS-1:0] BS_START,
    output logic [BSMODS-1:0] SERVE_REG,
    output logic [7:0]        LED
);

    localparam int unsigned IW = (BSMODS > 1) ? $clog2(BSMODS) : 1;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t            state, state_n;
    logic              armed, armed_n;
    logic              out_flag, out_n;
    logic [CW-1:0]     count, count_n;
    logic [CW:0]       done_cnt;
    logic [BSMODS-1:0] start_n, serve_n, rdy_q, rdy_n, launch;
    logic [7:0]        led_n;
    logic              found;
    logic [IW-1:0]     idx_w;
    int unsigned       base, idx;
`ifdef BLS_ROUND_ROBIN_EN
    logic [IW-1:0]     rr_ptr, rr_ptr_n;
`endif

    // Next-state, launch and serve arbitration
    always_comb begin
        state_n  = state;
        armed_n  = armed | DONE_WRITING;
        out_n    = out_flag | OutOfData;
        count_n  = count;
        done_cnt = '0;
        start_n  = BS_START;
        serve_n  = SERVE_REG;
        rdy_n    = BS_READY & BS_START;
        launch   = '0;
        found    = 1'b0;
        idx      = 0;
        idx_w    = '0;
`ifdef BLS_ROUND_ROBIN_EN
        rr_ptr_n = rr_ptr;
        base     = int'(rr_ptr);
`else
        base     = 0;
`endif

        for (int unsigned k = 0; k < BSMODS; k++)
            done_cnt = done_cnt + (CW+1)'(BS_DONE[k]);
        if (state != S_IDLE)
            count_n = count + CW'(done_cnt);

        case (state)
            S_IDLE:  if (armed_n) state_n = S_RUN;
            S_RUN:   if (out_n) state_n = S_DRAIN;
            S_DRAIN: if ((&BS_IDLE) && (hasUnusedData == '0) &&
                         (BS_START == '0) && (SERVE_REG == '0))
                         state_n = S_DONE;
            default: state_n = S_DONE;
        endcase

        // Start requests drop one clock after the acknowledge is sampled
        for (int unsigned k = 0; k < BSMODS; k++) begin
            if (BS_START[k]) begin
                if (rdy_q[k]) start_n[k] = 1'b0;
            end else if ((state == S_RUN || state == S_DRAIN) &&
                         REG_READY[k] && hasUnusedData[k] && BS_IDLE[k]) begin
                start_n[k] = 1'b1;
                launch[k]  = 1'b1;
            end
        end

        if (SERVE_REG != '0) begin
            if ((|(SERVE_REG & hasUnusedData)) || OutOfData || (state_n != S_RUN))
                serve_n = '0;
        end else if (state_n == S_RUN && !out_n) begin
            for (int unsigned i = 0; i < BSMODS; i++) begin
                idx = base + i;
                if (idx >= BSMODS) idx = idx - BSMODS;
                idx_w = IW'(idx);
                if (!found && !hasUnusedData[idx_w] && !BS_START[idx_w] && !launch[idx_w]) begin
                    found          = 1'b1;
                    serve_n[idx_w] = 1'b1;
`ifdef BLS_ROUND_ROBIN_EN
                    rr_ptr_n = (idx + 1 >= BSMODS) ? '0 : IW'(idx + 1);
`endif
                end
            end
        end

        led_n = {(state_n == S_DONE), 2'(state_n), count_n};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            out_flag  <= 1'b0;
            count     <= '0;
            BS_START  <= '0;
            SERVE_REG <= '0;
            rdy_q     <= '0;
            LED       <= '0;
`ifdef BLS_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_n;
            armed     <= armed_n;
            out_flag  <= out_n;
            count     <= count_n;
            BS_START  <= start_n;
            SERVE_REG <= serve_n;
            rdy_q     <= rdy_n;
            LED       <= led_n;
`ifdef BLS_ROUND_ROBIN_EN
            rr_ptr    <= rr_ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_bls_controller.sv
// Scoreboard bench for bls_controller: expected outputs queued per stimulus step.
module tb_bls_controller;

    localparam int unsigned N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         dw, ood;
    logic [N-1:0] bs_ready, bs_done, bs_idle, hud, reg_ready, bs_start, serve_reg;
    logic [7:0]   led;

    int errors = 0;
    int checks = 0;

    string        tag_q[$];
    logic [15:0]  exp_q[$];

    bls_controller #(.BSMODS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .DONE_WRITING (dw),
        .OutOfData    (ood),
        .BS_READY     (bs_ready),
        .BS_DONE      (bs_done),
        .BS_IDLE      (bs_idle),
        .hasUnusedData(hud),
        .REG_READY    (reg_ready),
        .BS_START     (bs_start),
        .SERVE_REG    (serve_reg),
        .LED          (led)
    );

    assign bs_ready = bs_start;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got start/serve/led=%h expected %h", tag, act, exp);
        end
    endtask

    // Queue the expectation, clock once, then compare against the oldest entry
    task automatic step(input string tag, input logic [3:0] s, input logic [3:0] v,
                        input logic [7:0] l);
        string       t;
        logic [15:0] e;
        tag_q.push_back(tag);
        exp_q.push_back({s, v, l});
        @(posedge clock);
        #1;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, {bs_start, serve_reg, led}, e);
    endtask

    initial begin
        int unsigned k;
        logic [3:0]  m;

        reset = 1'b0; dw = 1'b1; ood = 1'b0;
        bs_done = '0; bs_idle = 4'hF; hud = '0; reg_ready = '0;
        #2;
        check("reset_state", {bs_start, serve_reg, led}, 16'h0000);
        repeat (2) @(posedge clock);
        #1;
        dw = 1'b0;
        reset = 1'b1;
        step("dw_before_release_ignored", 4'h0, 4'h0, 8'h00);

        dw = 1'b1;
        step("run_serve0", 4'h0, 4'h1, 8'h20);
        dw = 1'b0; hud = 4'b0001;
        step("serve0_drop", 4'h0, 4'h0, 8'h20);
        step("serve1", 4'h0, 4'h2, 8'h20);
        hud = 4'b0011; reg_ready = 4'b0001;
        step("launch0", 4'h1, 4'h0, 8'h20);
        hud = 4'b0010; bs_idle = 4'b1110;
        step("start_hold", 4'h1, 4'h4, 8'h20);
        step("start_clear", 4'h0, 4'h4, 8'h20);
        bs_done = 4'b0011;
        step("count2", 4'h0, 4'h4, 8'h22);
        bs_done = 4'b0100;
        step("count3", 4'h0, 4'h4, 8'h23);
        bs_done = '0; ood = 1'b1;
        step("drain", 4'h0, 4'h0, 8'h43);
        ood = 1'b0;
        step("drain_hold", 4'h0, 4'h0, 8'h43);
        hud = '0; bs_idle = 4'hF; reg_ready = '0;
        step("done_state", 4'h0, 4'h0, 8'hE3);
        step("done_stay", 4'h0, 4'h0, 8'hE3);

        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1; dw = 1'b1; hud = 4'hF; reg_ready = 4'b0010;
        step("rerun", 4'h0, 4'h0, 8'h20);
        dw = 1'b0;
        step("launch1", 4'b0010, 4'h0, 8'h20);
        #2 reset = 1'b0;
        #1 check("async_reset", {bs_start, serve_reg, led}, 16'h0000);

        @(posedge clock);
        #1;
        reset = 1'b1; hud = '0; reg_ready = '0; ood = 1'b1;
        step("ood_in_idle", 4'h0, 4'h0, 8'h00);
        ood = 1'b0; dw = 1'b1; hud = 4'hF;
        step("ood_then_run", 4'h0, 4'h0, 8'h20);
        dw = 1'b0;
        step("ood_then_drain", 4'h0, 4'h0, 8'h40);

        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1; dw = 1'b1; hud = '0;
        for (int i = 0; i < 5; i++) begin
`ifdef BLS_ROUND_ROBIN_EN
            k = i % N;
`else
            k = 0;
`endif
            m = 4'(1) << k;
            step($sformatf("serve_order_%0d", i), 4'h0, m, 8'h20);
            dw = 1'b0; hud = m;
            step($sformatf("serve_ack_%0d", i), 4'h0, 4'h0, 8'h20);
            hud = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
